dctlb_inv_ctrl: RTL and testbench
=================================

# dctlb_inv_ctrl

Controller for the dctlb tag SRAM and entry valid bits. It arbitrates the single SRAM port between core lookups, miss refills and TLBI invalidations from the l2tlb, and owns the 64-entry valid-bit vector. It sequences 4KB invalidates as one read-compare-clear, and 2M/4M/1G invalidates as a 64-entry sweep, because the hashed index spreads a large page across all sets. It sits between the dctlb lookup pipeline, the refill path and the l2tlb TLBI channel.

## Interface
- ENTRIES, 64, number of dctlb entries (index width 6)
- VPNW, 27, virtual page number width (Sv39)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- lookup_valid  in  1  core lookup this cycle; highest SRAM priority
- lookup_idx  in  6  hashed lookup index
- lookup_entry_valid  out  1  registered; valid bit of lookup_idx one cycle later, aligned with SRAM data
- fill_valid / fill_ready  in / out  1 / 1  refill handshake
- fill_idx  in  6;  fill_vpn  in  VPNW  refill entry index and tag
- inv_valid / inv_ready  in / out  1 / 1  TLBI handshake
- inv_type  in  3  0=4K, 1=2M, 2=4M, 3=1G, 4=ALL; 5-7 are treated as ALL
- inv_vpn  in  VPNW;  inv_idx  in  6  (hashed index, used for 4K only)
- inv_done  out  1  registered one-cycle pulse at invalidate completion
- inv_hits  out  7  registered count of entries cleared by the last invalidate, held until the next inv_done
- sram_req, sram_we  out  1, 1;  sram_idx  out  6;  sram_wvpn  out  VPNW  tag SRAM port
- sram_rvpn  in  VPNW  read data, valid the cycle after a read request

## Operation
- States: IDLE, PROBE, SWEEP, DONE. inv_ready = (state==IDLE). fill_ready = IDLE & !lookup_valid & !inv_valid.
- SRAM mux, in priority order:
  - lookup: read at lookup_idx.
  - controller read in PROBE/SWEEP.
  - fill write: sram_we=1, sets valid[fill_idx] at the same edge.
- An invalidate read is stalled, not dropped, in any cycle where lookup_valid=1.
- Compare masks: 4K uses all bits. 2M ignores vpn[8:0]. 4M ignores vpn[9:0]. 1G ignores vpn[17:0]. Compared fields are sram_rvpn vs inv_vpn (both captured or registered).
- A match clears the valid bit. A match is counted in inv_hits only if the valid bit was set.
- ALL: on accept, clear all valid bits, set inv_hits = popcount(valid), go to DONE.
- 4K: accept → PROBE. Issue one read at the captured inv_idx, compare on the data-return cycle, then go to DONE.
- 2M/4M/1G: accept → SWEEP with a 6-bit counter at 0.
  - Each non-stalled cycle reads idx=counter and increments it.
  - Compare is pipelined one cycle behind the read, with a registered rd_pend flag and rd_idx.
  - Leave to DONE after the compare for index 63.
  - Counter wraps 63→0 but is never reused.
- DONE: inv_done=1 for one cycle, then IDLE.
- Fills are accepted only in IDLE, so a fill never races an invalidate.
- lookup_entry_valid reports the next-state valid bit, including any clear at that edge.
- inv_valid and fill_valid in the same IDLE cycle: invalidate wins.

## Timing
- Reset (asserted low, async): valid[63:0]=0, state IDLE, counter 0, rd_pend 0, inv_done 0, inv_hits 0, lookup_entry_valid 0. Combinational outputs follow: sram_req 0 unless lookup_valid, inv_ready 1, fill_ready 1 when no lookup and no inv.
- Reset mid-sweep: aborts immediately. All valid bits cleared, no inv_done.
- Invalidate accepted at the end of cycle T, no lookup interference:
  - ALL: done T+1.
  - 4K: read T+1, compare/clear T+2, inv_done T+3.
  - Sweep: reads T+1..T+64, last compare T+65, inv_done T+66.
- Each lookup_valid cycle during PROBE/SWEEP delays completion by exactly one cycle.
- Fill: fill_valid & fill_ready at T → SRAM write in T, valid set at the end of T.
- Lookup: lookup at T → lookup_entry_valid at T+1.

## Test plan
- After reset, fill idx 5 with vpn 0x0001234, then lookup idx 5 → lookup_entry_valid=1 next cycle. Lookup idx 6 → 0.
- Fill idx 5 with vpn 0x0001234; inv 4K vpn 0x0001234 idx 5 → inv_done at T+3, inv_hits=1, lookup idx 5 → 0. Repeat with vpn 0x0001235 → inv_hits=0, entry stays valid.
- Fill idx 3/17/40 with vpns 0x0000200, 0x00003FF, 0x0000400; inv 2M vpn 0x0000300 → idx 3 and 17 cleared, idx 40 kept, inv_hits=2, inv_done at T+66.
- The same sweep with lookup_valid high for 10 cycles mid-sweep → inv_done at T+76. fill_ready stays 0 throughout, and no entry is skipped.
- Fill 8 entries; inv ALL → all cleared, inv_hits=8, inv_done at T+1.
- Assert reset at sweep index 30 → all outputs at reset values, no inv_done, inv_ready=1 after release.

Source files
------------

// File: rtl/dctlb_inv_ctrl_if.sv
// Bundle of dctlb_inv_ctrl signals: core lookup, refill, TLBI channel and the tag SRAM port.
// The slave side is the controller; the master side is the surrounding dctlb and l2tlb logic.
interface dctlb_inv_ctrl_if #(
  parameter int ENTRIES = 64,
  parameter int VPNW    = 27
);
  localparam int IDXW = $clog2(ENTRIES);

  logic            lookup_valid;
  logic [IDXW-1:0] lookup_idx;
  logic            lookup_entry_valid;

  logic            fill_valid;
  logic            fill_ready;
  logic [IDXW-1:0] fill_idx;
  logic [VPNW-1:0] fill_vpn;

  logic            inv_valid;
  logic            inv_ready;
  logic [2:0]      inv_type;
  logic [VPNW-1:0] inv_vpn;
  logic [IDXW-1:0] inv_idx;
  logic            inv_done;
  logic [6:0]      inv_hits;

  logic            sram_req;
  logic            sram_we;
  logic [IDXW-1:0] sram_idx;
  logic [VPNW-1:0] sram_wvpn;
  logic [VPNW-1:0] sram_rvpn;

  modport master (
    output lookup_valid, lookup_idx,
    input  lookup_entry_valid,
    output fill_valid, fill_idx, fill_vpn,
    input  fill_ready,
    output inv_valid, inv_type, inv_vpn, inv_idx,
    input  inv_ready, inv_done, inv_hits,
    input  sram_req, sram_we, sram_idx, sram_wvpn,
    output sram_rvpn
  );

  modport slave (
    input  lookup_valid, lookup_idx,
    output lookup_entry_valid,
    input  fill_valid, fill_idx, fill_vpn,
    output fill_ready,
    input  inv_valid, inv_type, inv_vpn, inv_idx,
    output inv_ready, inv_done, inv_hits,
    output sram_req, sram_we, sram_idx, sram_wvpn,
    input  sram_rvpn
  );
endinterface

// File: rtl/dctlb_inv_ctrl.sv
// dctlb tag SRAM arbiter and valid-bit owner: 4K invalidates probe one set, larger pages
// sweep all entries (hashed index scatters them), ALL clears the vector in one cycle.
module dctlb_inv_ctrl #(
  parameter int ENTRIES = 64,
  parameter int VPNW    = 27
) (
  input  logic              clk,
  input  logic              reset,
  dctlb_inv_ctrl_if.slave   bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, PROBE, SWEEP, DONE} state_t;

  state_t             state;
  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] valid_nxt;
  logic [IDXW-1:0]    cnt;
  logic [IDXW-1:0]    rd_idx;
  logic [IDXW-1:0]    inv_idx_q;
  logic [IDXW-1:0]    rd_addr;
  logic               rd_pend;
  logic [VPNW-1:0]    vpn_q;
  logic [VPNW-1:0]    mask_q;
  logic [VPNW-1:0]    mask_sel;
  logic [6:0]         hit_cnt;
  logic [6:0]         hit_nxt;
  logic               inv_go;
  logic               inv_all;
  logic               fill_go;
  logic               ctl_rd;
  logic               match;
  logic               last_cmp;

  // Types 4..7 all mean "invalidate everything".
  assign inv_all  = bus.inv_type[2];
  assign inv_go   = (state == IDLE) && bus.inv_valid;
  assign fill_go  = bus.fill_valid && bus.fill_ready;
  assign last_cmp = rd_pend && (rd_idx == LAST_IDX);
  assign rd_addr  = (state == PROBE) ? inv_idx_q : cnt;

  // The controller read yields to a lookup; it is retried the next cycle rather than dropped.
  assign ctl_rd = !bus.lookup_valid &&
                  (((state == PROBE) && !rd_pend) || ((state == SWEEP) && !last_cmp));
  assign match  = rd_pend && (((bus.sram_rvpn ^ vpn_q) & mask_q) == '0);

  assign bus.inv_ready  = (state == IDLE);
  assign bus.fill_ready = (state == IDLE) && !bus.lookup_valid && !bus.inv_valid;
  assign bus.sram_req   = bus.lookup_valid || ctl_rd || fill_go;
  assign bus.sram_we    = fill_go;
  assign bus.sram_idx   = bus.lookup_valid ? bus.lookup_idx :
                          ctl_rd           ? rd_addr        : bus.fill_idx;
  assign bus.sram_wvpn  = bus.fill_vpn;

  // NOTE: every always_comb output gets a default first, otherwise an unassigned path infers a latch.
  always_comb begin
    mask_sel = '1;
    unique case (bus.inv_type)
      3'd1:    mask_sel = {{(VPNW-9){1'b1}},  9'b0};
      3'd2:    mask_sel = {{(VPNW-10){1'b1}}, 10'b0};
      3'd3:    mask_sel = {{(VPNW-18){1'b1}}, 18'b0};
      default: mask_sel = '1;
    endcase
  end

  always_comb begin
    valid_nxt = valid;
    if (fill_go)          valid_nxt[bus.fill_idx] = 1'b1;
    if (match)            valid_nxt[rd_idx]       = 1'b0;
    if (inv_go && inv_all) valid_nxt              = '0;
  end

  // Only entries that were actually valid count as hits.
  always_comb begin
    hit_nxt = hit_cnt;
    if (inv_go)                   hit_nxt = inv_all ? 7'($countones(valid)) : 7'd0;
    if (match && valid[rd_idx])   hit_nxt = hit_cnt + 7'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the valid vector is a real reset target (it gates hits); the tag SRAM itself is never reset.
      state                  <= IDLE;
      valid                  <= '0;
      cnt                    <= '0;
      rd_pend                <= 1'b0;
      rd_idx                 <= '0;
      inv_idx_q              <= '0;
      vpn_q                  <= '0;
      mask_q                 <= '0;
      hit_cnt                <= '0;
      bus.inv_done           <= 1'b0;
      bus.inv_hits           <= '0;
      bus.lookup_entry_valid <= 1'b0;
    end else begin
      valid                  <= valid_nxt;
      hit_cnt                <= hit_nxt;
      rd_pend                <= ctl_rd;
      bus.lookup_entry_valid <= valid_nxt[bus.lookup_idx];
      bus.inv_done           <= 1'b0;
      if (ctl_rd) rd_idx <= rd_addr;

      unique case (state)
        IDLE: begin
          if (bus.inv_valid) begin
            vpn_q     <= bus.inv_vpn;
            mask_q    <= mask_sel;
            inv_idx_q <= bus.inv_idx;
            cnt       <= '0;
            if (inv_all) begin
              state        <= DONE;
              bus.inv_done <= 1'b1;
              bus.inv_hits <= hit_nxt;
            end else if (bus.inv_type == 3'd0) begin
              state <= PROBE;
            end else begin
              state <= SWEEP;
            end
          end
        end
        PROBE: begin
          if (rd_pend) begin
            state        <= DONE;
            bus.inv_done <= 1'b1;
            bus.inv_hits <= hit_nxt;
          end
        end
        SWEEP: begin
          if (ctl_rd) cnt <= cnt + IDXW'(1);
          if (last_cmp) begin
            state        <= DONE;
            bus.inv_done <= 1'b1;
            bus.inv_hits <= hit_nxt;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dctlb_inv_ctrl.sv
// Directed bench for dctlb_inv_ctrl with a behavioural tag SRAM; inputs change and outputs
// are sampled on the falling edge.
module tb_dctlb_inv_ctrl;
  localparam int VPNW = 27;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dctlb_inv_ctrl_if #(.ENTRIES(64), .VPNW(VPNW)) bus ();
  dctlb_inv_ctrl #(.ENTRIES(64), .VPNW(VPNW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [VPNW-1:0] mem [64];
  logic [VPNW-1:0] rd_q;

  always @(posedge clk) begin
    if (bus.sram_req) begin
      if (bus.sram_we) mem[bus.sram_idx] <= bus.sram_wvpn;
      else             rd_q <= mem[bus.sram_idx];
    end
  end
  assign bus.sram_rvpn = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_entry(input logic [5:0] idx, input logic [VPNW-1:0] vpn);
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_idx   = idx;
    bus.fill_vpn   = vpn;
    check("fill_ready", 32'(bus.fill_ready), 32'd1);
    @(negedge clk);
    bus.fill_valid = 1'b0;
  endtask

  task automatic lookup_chk(input string tag, input logic [5:0] idx, input logic exp);
    @(negedge clk);
    bus.lookup_valid = 1'b1;
    bus.lookup_idx   = idx;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    check(tag, 32'(bus.lookup_entry_valid), 32'(exp));
  endtask

  // Issues one invalidate, optionally drives lookups in cycles T+stall_from.., and checks
  // the completion latency (cycles after the accept edge) and the hit count.
  task automatic run_inv(input string tag, input logic [2:0] t, input logic [VPNW-1:0] vpn,
                         input logic [5:0] idx, input int exp_lat, input int exp_hits,
                         input int stall_from, input int stall_len);
    int  lat;
    bit  fr_bad;
    lat    = -1;
    fr_bad = 1'b0;
    @(negedge clk);
    bus.inv_valid = 1'b1;
    bus.inv_type  = t;
    bus.inv_vpn   = vpn;
    bus.inv_idx   = idx;
    check({tag, "_ready"}, 32'(bus.inv_ready), 32'd1);
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      @(negedge clk);
      bus.inv_valid = 1'b0;
      if (bus.inv_done) begin
        lat = k;
      end else begin
        if (bus.fill_ready) fr_bad = 1'b1;
        bus.lookup_valid = (k >= stall_from) && (k < stall_from + stall_len);
        bus.lookup_idx   = 6'd40;
      end
    end
    bus.lookup_valid = 1'b0;
    check({tag, "_lat"},  32'(lat),          32'(exp_lat));
    check({tag, "_hits"}, 32'(bus.inv_hits), 32'(exp_hits));
    check({tag, "_fill_blocked"}, 32'(fr_bad), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.inv_done), 32'd0);
    check({tag, "_idle"},       32'(bus.inv_ready), 32'd1);
  endtask

  initial begin
    bit saw_done;
    for (int i = 0; i < 64; i++) mem[i] = '1;
    rd_q             = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_idx   = '0;
    bus.fill_valid   = 1'b0;
    bus.fill_idx     = '0;
    bus.fill_vpn     = '0;
    bus.inv_valid    = 1'b0;
    bus.inv_type     = '0;
    bus.inv_vpn      = '0;
    bus.inv_idx      = '0;

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_inv_done",   32'(bus.inv_done),           32'd0);
    check("rst_inv_hits",   32'(bus.inv_hits),           32'd0);
    check("rst_lookup_ev",  32'(bus.lookup_entry_valid), 32'd0);
    check("rst_inv_ready",  32'(bus.inv_ready),          32'd1);
    check("rst_fill_ready", 32'(bus.fill_ready),         32'd1);
    check("rst_sram_req",   32'(bus.sram_req),           32'd0);

    // Fill then lookup.
    fill_entry(6'd5, 27'h0001234);
    lookup_chk("lookup5_set",   6'd5, 1'b1);
    lookup_chk("lookup6_clear", 6'd6, 1'b0);

    // 4K hit and 4K miss.
    run_inv("inv4k_hit", 3'd0, 27'h0001234, 6'd5, 3, 1, 0, 0);
    lookup_chk("lookup5_after_hit", 6'd5, 1'b0);
    fill_entry(6'd5, 27'h0001234);
    run_inv("inv4k_miss", 3'd0, 27'h0001235, 6'd5, 3, 0, 0, 0);
    lookup_chk("lookup5_after_miss", 6'd5, 1'b1);

    // 2M sweep: 0x200 and 0x3FF share vpn[26:9] with 0x300, 0x400 and 0x1234 do not.
    fill_entry(6'd3,  27'h0000200);
    fill_entry(6'd17, 27'h00003FF);
    fill_entry(6'd40, 27'h0000400);
    run_inv("inv2m", 3'd1, 27'h0000300, 6'd0, 66, 2, 0, 0);
    lookup_chk("2m_idx3",  6'd3,  1'b0);
    lookup_chk("2m_idx17", 6'd17, 1'b0);
    lookup_chk("2m_idx40", 6'd40, 1'b1);
    lookup_chk("2m_idx5",  6'd5,  1'b1);

    // Same sweep with ten lookup cycles in the middle.
    fill_entry(6'd3,  27'h0000200);
    fill_entry(6'd17, 27'h00003FF);
    run_inv("inv2m_stall", 3'd1, 27'h0000300, 6'd0, 76, 2, 20, 10);
    lookup_chk("2ms_idx3",  6'd3,  1'b0);
    lookup_chk("2ms_idx17", 6'd17, 1'b0);
    lookup_chk("2ms_idx40", 6'd40, 1'b1);

    // 4M ignores vpn[9:0]: 0x3FF matches 0, 0x400 does not.
    fill_entry(6'd3, 27'h00003FF);
    run_inv("inv4m", 3'd2, 27'h0000000, 6'd0, 66, 1, 0, 0);
    lookup_chk("4m_idx3",  6'd3,  1'b0);
    lookup_chk("4m_idx40", 6'd40, 1'b1);

    // 1G ignores vpn[17:0]: valid 5 and 40 hit; stale tags at 3/17 match but are not counted.
    run_inv("inv1g", 3'd3, 27'h003FFFF, 6'd0, 66, 2, 0, 0);
    lookup_chk("1g_idx5",  6'd5,  1'b0);
    lookup_chk("1g_idx40", 6'd40, 1'b0);

    // ALL and an out-of-range type that behaves as ALL.
    for (int i = 0; i < 8; i++) fill_entry(6'(i), 27'(i + 1));
    run_inv("inv_all", 3'd4, 27'h0, 6'd0, 1, 8, 0, 0);
    lookup_chk("all_idx0", 6'd0, 1'b0);
    lookup_chk("all_idx7", 6'd7, 1'b0);
    fill_entry(6'd20, 27'h0000020);
    fill_entry(6'd21, 27'h0000021);
    run_inv("inv_type7", 3'd7, 27'h0, 6'd0, 1, 2, 0, 0);

    // Reset in the middle of a sweep, while idx 30 is being read.
    fill_entry(6'd10, 27'h7000000);
    lookup_chk("pre_rst_idx10", 6'd10, 1'b1);
    @(negedge clk);
    bus.inv_valid = 1'b1;
    bus.inv_type  = 3'd1;
    bus.inv_vpn   = 27'h0;
    @(negedge clk);
    bus.inv_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_sweep_busy", 32'(bus.inv_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("arst_inv_done",   32'(bus.inv_done),           32'd0);
    check("arst_inv_hits",   32'(bus.inv_hits),           32'd0);
    check("arst_lookup_ev",  32'(bus.lookup_entry_valid), 32'd0);
    check("arst_inv_ready",  32'(bus.inv_ready),          32'd1);
    check("arst_fill_ready", 32'(bus.fill_ready),         32'd1);
    check("arst_sram_req",   32'(bus.sram_req),           32'd0);
    @(negedge clk);
    reset    = 1'b1;
    saw_done = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.inv_done) saw_done = 1'b1;
    end
    check("arst_no_done",   32'(saw_done),      32'd0);
    check("arst_ready_rel", 32'(bus.inv_ready), 32'd1);
    lookup_chk("arst_idx10", 6'd10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
